// File: rtl/mips_mem_pkg.sv
// Shared types for the MIPS data-memory responder: byte/word lane types and FSM encoding.
package mips_mem_pkg;

  typedef logic [7:0] byte_t;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  typedef byte_t word_bytes_t [0:WORD_BYTES-1];

endpackage

// File: rtl/mips_byte_ram.sv
// Byte-wide storage with synchronous 4-lane write and four combinational read ports.
// Contents are never reset.
module mips_byte_ram
  import mips_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i [0:WORD_BYTES-1],
  input  logic [7:0]            wdata_i [0:WORD_BYTES-1],
  input  logic [ADDR_WIDTH-1:0] raddr_i [0:WORD_BYTES-1],
  output logic [7:0]            rdata_o [0:WORD_BYTES-1]
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  byte_t mem_q [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        mem_q[waddr_i[i]] <= wdata_i[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < WORD_BYTES; i++) begin
      rdata_o[i] = mem_q[raddr_i[i]];
    end
  end

endmodule

// File: rtl/mips_data_memory.sv
// Data-memory responder for the MIPS load/store port: one word request at a time, fixed latency.
// Optional alignment checking is enabled by defining MIPS_DMEM_ALIGN_CHECK_EN.
module mips_data_memory
  import mips_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [7:0]  req_wdata  [0:WORD_BYTES-1],
  output logic        resp_valid,
  output logic [7:0]  resp_rdata [0:WORD_BYTES-1],
  output logic        resp_err
);

  localparam int CNT_W = 4;

  if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
    $error("mips_data_memory: LATENCY must be in the range 1..15");
  end

  dmem_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  we_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  byte_t                 wdata_q  [0:WORD_BYTES-1];
  byte_t                 rdata_q  [0:WORD_BYTES-1];
  byte_t                 respData [0:WORD_BYTES-1];
  byte_t                 ramRdata [0:WORD_BYTES-1];
  logic [ADDR_WIDTH-1:0] laneAddr [0:WORD_BYTES-1];
  logic                  accept;
  logic                  misaligned;
  logic                  ramWe;

  if (ADDR_WIDTH < 32) begin : g_unused_addr
    logic unusedAddrBits;
    assign unusedAddrBits = ^req_addr[31:ADDR_WIDTH];
  end

`ifdef MIPS_DMEM_ALIGN_CHECK_EN
  assign misaligned = (req_addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign req_ready  = (state_q == IDLE) && !rst;
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_q == RESP) && !rst;
  assign resp_err   = resp_valid && err_q;
  assign ramWe      = (state_q == RESP) && we_q && !err_q && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_q counts cycles already spent since accept; WAIT exits once LATENCY-1 have elapsed
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = CNT_W'(1);
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(LATENCY - 1)) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q   <= 1'b0;
      err_q  <= 1'b0;
      addr_q <= '0;
      for (int i = 0; i < WORD_BYTES; i++) begin
        wdata_q[i] <= '0;
      end
    end else if (accept) begin
      we_q   <= req_we;
      err_q  <= misaligned;
      addr_q <= req_addr[ADDR_WIDTH-1:0];
      for (int i = 0; i < WORD_BYTES; i++) begin
        wdata_q[i] <= req_wdata[i];
      end
    end
  end

  // Lane addresses wrap inside the truncated address space
  always_comb begin
    for (int i = 0; i < WORD_BYTES; i++) begin
      laneAddr[i] = addr_q + ADDR_WIDTH'(i);
    end
  end

  mips_byte_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .we_i   (ramWe),
    .waddr_i(laneAddr),
    .wdata_i(wdata_q),
    .raddr_i(laneAddr),
    .rdata_o(ramRdata)
  );

  always_comb begin
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (err_q) begin
        respData[i] = '0;
      end else if (we_q) begin
        respData[i] = wdata_q[i];
      end else begin
        respData[i] = ramRdata[i];
      end
    end
  end

  // Between responses the last response word is replayed from rdata_q
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        rdata_q[i] <= '0;
      end
    end else if (state_q == RESP) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        rdata_q[i] <= respData[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (rst) begin
        resp_rdata[i] = '0;
      end else if (state_q == RESP) begin
        resp_rdata[i] = respData[i];
      end else begin
        resp_rdata[i] = rdata_q[i];
      end
    end
  end

endmodule
